// File: rtl/victim_way_arb_pkg.sv
// Shared constants for the victim-way arbiter: reset polarity, LFSR seed,
// requester IDs and the LFSR next-state function.
package victim_way_arb_pkg;

   localparam logic       RstEnable = 1'b0;
   localparam logic [7:0] LfsrSeed  = 8'hFF;

   localparam int ReqICache = 0;
   localparam int ReqDCache = 1;
   localparam int ReqTLB    = 2;

   localparam int NREQ_DEF      = 3;
   localparam int WAYS_LOG2_DEF = 2;

   // Galois form: bit 7 feeds back into bits 0, 4, 5 and 6.
   function automatic logic [7:0] lfsr8_next(input logic [7:0] r);
      logic [7:0] n;
      n[0] = r[7];
      n[1] = r[0];
      n[2] = r[1];
      n[3] = r[2];
      n[4] = r[3] ^ r[7];
      n[5] = r[4] ^ r[7];
      n[6] = r[5] ^ r[7];
      n[7] = r[6];
      return n;
   endfunction

endpackage

// File: rtl/victim_way_arb_if.sv
// Request/grant bundle between the refill FSMs (master) and the arbiter (slave).
// Handshake: req_i is a level held until the matching gnt_o bit pulses for one
// cycle; the requester drops req_i[i] in that cycle; way_o is valid only while gnt_o != 0.
interface victim_way_arb_if #(
   parameter int NREQ      = 3,
   parameter int WAYS_LOG2 = 2
);
   localparam int WAYS = 1 << WAYS_LOG2;

   logic [NREQ-1:0]      req_i;
   logic [NREQ*WAYS-1:0] valid_mask_i;
   logic [NREQ-1:0]      gnt_o;
   logic [WAYS_LOG2-1:0] way_o;

   modport master (output req_i, valid_mask_i, input gnt_o, way_o);
   modport slave  (input req_i, valid_mask_i, output gnt_o, way_o);
endinterface

// File: rtl/victim_way_arb_rand_lfsr8.sv
// rand_lfsr8: 8-bit Galois LFSR that steps only when en is high; seeded from
// the shared package on asynchronous active-low reset.
module rand_lfsr8
   import victim_way_arb_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   output logic [7:0] value
);

   logic [7:0] state;

   always_ff @(posedge clk or negedge rst) begin
      if (rst == RstEnable) begin
         state <= LfsrSeed;
      end else if (en) begin
         state <= lfsr8_next(state);
      end
   end

   assign value = state;

endmodule

// File: rtl/victim_way_arb.sv
// victim_way_arb: round-robin arbiter sharing one LFSR among refill requesters.
// Optional feature macro: VICTIM_INVALID_FIRST_EN (prefer lowest invalid way).
module victim_way_arb
   import victim_way_arb_pkg::*;
#(
   parameter int NREQ      = NREQ_DEF,
   parameter int WAYS_LOG2 = WAYS_LOG2_DEF
) (
   input  logic            clk,
   input  logic            rst,
   victim_way_arb_if.slave bus
);

   localparam int WAYS  = 1 << WAYS_LOG2;
   localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef logic [PTR_W-1:0] ptr_t;

   ptr_t                 ptr;
   ptr_t                 win;
   ptr_t                 cand;
   ptr_t                 next_ptr;
   logic                 found;
   logic [NREQ-1:0]      elig;
   logic [NREQ-1:0]      gnt_q;
   logic [WAYS_LOG2-1:0] way_q;
   logic [WAYS_LOG2-1:0] victim;
   logic [7:0]           lfsr;

   // Masking with the registered grant keeps a requester from winning twice in a row.
   always_comb begin
      elig  = bus.req_i & ~gnt_q;
      found = 1'b0;
      win   = '0;
      cand  = ptr;
      for (int o = 0; o < NREQ; o++) begin
         if (!found && elig[cand]) begin
            found = 1'b1;
            win   = cand;
         end
         cand = (cand == ptr_t'(NREQ - 1)) ? '0 : cand + 1'b1;
      end
      next_ptr = (win == ptr_t'(NREQ - 1)) ? '0 : win + 1'b1;
   end

`ifdef VICTIM_INVALID_FIRST_EN
   logic [WAYS-1:0] slice;

   always_comb begin
      slice = '1;
      for (int r = 0; r < NREQ; r++) begin
         if (win == ptr_t'(r)) slice = bus.valid_mask_i[r*WAYS +: WAYS];
      end
      victim = lfsr[WAYS_LOG2-1:0];
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!slice[w]) victim = WAYS_LOG2'(w);
      end
   end
`else
   logic unused_mask;

   assign unused_mask = ^bus.valid_mask_i;
   assign victim      = lfsr[WAYS_LOG2-1:0];
`endif

   rand_lfsr8 u_lfsr (
      .clk   (clk),
      .rst   (rst),
      .en    (found),
      .value (lfsr)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (rst == RstEnable) begin
         gnt_q <= '0;
         way_q <= '0;
         ptr   <= '0;
      end else begin
         gnt_q <= found ? (NREQ'(1) << win) : '0;
         if (found) begin
            way_q <= victim;
            ptr   <= next_ptr;
         end
      end
   end

   assign bus.gnt_o = gnt_q;
   assign bus.way_o = way_q;

endmodule

// File: tb/tb_victim_way_arb.sv
// Directed bench for victim_way_arb with a spec-level reference model and an
// expected-value queue; honours VICTIM_INVALID_FIRST_EN when defined.
module tb_victim_way_arb;

   localparam int NREQ      = 3;
   localparam int WAYS_LOG2 = 2;

   logic        clk;
   logic        rst;
   logic [2:0]  req;
   logic [11:0] mask;

   victim_way_arb_if #(.NREQ(NREQ), .WAYS_LOG2(WAYS_LOG2)) bus ();

   assign bus.req_i        = req;
   assign bus.valid_mask_i = mask;

   victim_way_arb #(.NREQ(NREQ), .WAYS_LOG2(WAYS_LOG2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int fails  = 0;

   logic [4:0] exp_q[$];

   logic [7:0] m_lfsr;
   int         m_ptr;
   logic [2:0] m_gnt;
   logic [1:0] m_way;
   logic [2:0] prev_gnt;
   logic [1:0] got_way[4];

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] model_lfsr_step(input logic [7:0] r);
      return {r[6], r[5] ^ r[7], r[4] ^ r[7], r[3] ^ r[7], r[2], r[1], r[0], r[7]};
   endfunction

   function automatic logic [1:0] model_victim(input int k);
      logic [3:0] sl;
      sl = 4'(mask >> (k * 4));
`ifdef VICTIM_INVALID_FIRST_EN
      for (int w = 0; w < 4; w++) begin
         if (!sl[w]) return 2'(w);
      end
`else
      sl = 4'hF;
`endif
      return m_lfsr[1:0] & {2{sl[0] | 1'b1}};
   endfunction

   task automatic model_reset();
      m_lfsr   = 8'hFF;
      m_ptr    = 0;
      m_gnt    = 3'b000;
      m_way    = 2'd0;
      prev_gnt = 3'b000;
   endtask

   // Predict the next edge, push it, then compare at #1 after the edge.
   task automatic edge_check();
      logic [2:0] elig;
      logic [2:0] eg;
      logic [1:0] ew;
      logic [4:0] e;
      int         k;
      int         idx;
      elig = req & ~m_gnt;
      eg   = 3'b000;
      ew   = m_way;
      k    = -1;
      for (int o = 0; o < NREQ; o++) begin
         idx = (m_ptr + o) % NREQ;
         if (k < 0 && elig[idx]) k = idx;
      end
      if (k >= 0) begin
         eg     = 3'(1 << k);
         ew     = model_victim(k);
         m_lfsr = model_lfsr_step(m_lfsr);
         m_ptr  = (k + 1) % NREQ;
      end
      m_gnt = eg;
      m_way = ew;
      exp_q.push_back({eg, ew});
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk("gnt", 8'(bus.gnt_o), 8'(e[4:2]));
      if (e[4:2] != 3'b000) chk("way", 8'(bus.way_o), 8'(e[1:0]));
      chk("no_b2b", 8'(prev_gnt & bus.gnt_o), 8'h00);
      prev_gnt = bus.gnt_o;
   endtask

   task automatic step(input bit drop);
      edge_check();
      if (drop) req = req & ~bus.gnt_o;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      req = 3'b000;
      #1;
      chk("rst_gnt", 8'(bus.gnt_o), 8'h00);
      chk("rst_way", 8'(bus.way_o), 8'h00);
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      rst  = 1'b0;
      req  = 3'b000;
      mask = 12'hFFF;
      model_reset();
      #12;
      chk("init_gnt", 8'(bus.gnt_o), 8'h00);
      chk("init_way", 8'(bus.way_o), 8'h00);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // ICache alone, four separate requests: ways 3,3,3,2
      for (int i = 0; i < 4; i++) begin
         req = 3'b001;
         step(1'b1);
         got_way[i] = bus.way_o;
         step(1'b0);
      end
      chk("t1_way0", 8'(got_way[0]), 8'd3);
      chk("t1_way1", 8'(got_way[1]), 8'd3);
      chk("t1_way2", 8'(got_way[2]), 8'd3);
      chk("t1_way3", 8'(got_way[3]), 8'd2);

      // All three at once from pointer 0
      do_reset();
      req = 3'b111;
      step(1'b1);
      chk("t2_g0", 8'(bus.gnt_o), 8'h01);
      step(1'b1);
      chk("t2_g1", 8'(bus.gnt_o), 8'h02);
      step(1'b1);
      chk("t2_g2", 8'(bus.gnt_o), 8'h04);
      step(1'b0);

      // DCache holds its request without dropping
      req = 3'b010;
      for (int i = 0; i < 8; i++) step(1'b0);
      req = 3'b000;
      step(1'b0);

      // Invalid-way preference on the DCache slice
      do_reset();
      mask = 12'hFBF;
      req  = 3'b010;
      step(1'b1);
`ifdef VICTIM_INVALID_FIRST_EN
      chk("t4_inval", 8'(bus.way_o), 8'd2);
`else
      chk("t4_rand", 8'(bus.way_o), 8'd3);
`endif
      step(1'b0);
      mask = 12'hFFF;
      req  = 3'b010;
      step(1'b1);
      chk("t4_full", 8'(bus.way_o), 8'd3);
      step(1'b0);

      // Reset while a TLB grant is on the outputs
      do_reset();
      req = 3'b100;
      edge_check();
      chk("t5_pre", 8'(bus.gnt_o), 8'h04);
      #1;
      rst = 1'b0;
      req = 3'b000;
      #1;
      chk("t5_async_gnt", 8'(bus.gnt_o), 8'h00);
      chk("t5_async_way", 8'(bus.way_o), 8'h00);
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      req = 3'b100;
      step(1'b1);
      chk("t5_seed_way", 8'(bus.way_o), 8'd3);
      step(1'b0);

      // Pointer restarts at 0 after reset even if it had moved
      req = 3'b001;
      step(1'b1);
      step(1'b0);
      do_reset();
      req = 3'b011;
      step(1'b1);
      chk("t5_ptr0", 8'(bus.gnt_o), 8'h01);
      step(1'b1);
      step(1'b0);

      // Long idle gap between grants leaves the LFSR alone
      do_reset();
      req = 3'b001;
      step(1'b1);
      for (int i = 0; i < 100; i++) step(1'b0);
      req = 3'b001;
      step(1'b1);
      chk("t6_after_idle", 8'(bus.way_o), 8'd3);
      step(1'b0);
      req = 3'b001;
      step(1'b1);
      step(1'b0);
      req = 3'b001;
      step(1'b1);
      chk("t6_seq_ee", 8'(bus.way_o), 8'd2);
      step(1'b0);

      chk("queue_empty", 8'(exp_q.size()), 8'd0);
      $display("== %0d vectors applied, %0d miscompares ==", checks, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
